ctrl_pattern_gen: RTL and testbench

CTRL_PATTERN_GEN -- requirements
Module: ctrl_pattern_gen

---
 rtl/ctrl_pattern_gen_pkg.sv | 19 +
 rtl/ctrl_pattern_gen_mismatch_filter.sv | 60 ++++++
 rtl/ctrl_pattern_gen.sv | 146 ++++++++++++++
 tb/tb_ctrl_pattern_gen.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pattern_gen_pkg.sv
// Shared constants for the relay/heartbeat pattern generator: heartbeat
// FSM encoding and the default phase lengths and disagreement limit.
package ctrl_pattern_gen_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHORT = 2'd1;
    localparam logic [1:0] ST_LONG  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam int DEF_SHORT_LEN    = 2;
    localparam int DEF_LONG_LEN     = 16;
    localparam int DEF_MISMATCH_LIM = 3;

    // Last phase-counter value of a phase lasting len cycles (counter starts at 0).
    function automatic logic [4:0] phase_last(input int len);
        return 5'(len - 1);
    endfunction

endpackage

// File: rtl/ctrl_pattern_gen_mismatch_filter.sv
// Channel-disagreement filter: counts consecutive cycles in which the two
// redundant relay commands differ and latches a fault once the run is long
// enough. The fault is released only by a clear request while the channels agree.
module mismatch_filter
    import ctrl_pattern_gen_pkg::*;
#(
    parameter int MISMATCH_LIM = DEF_MISMATCH_LIM
) (
    input  logic clk,
    input  logic rst,
    input  logic i_cmd_a,
    input  logic i_cmd_b,
    input  logic i_fault_clr,
    output logic o_fault,
    output logic o_clr_evt
);

    localparam logic [3:0] LIM = 4'(MISMATCH_LIM);

    logic [3:0] r_cnt;
    logic       r_fault;
    logic       w_equal;
    logic       w_clr;
    logic [3:0] w_cnt_nxt;

    assign w_equal = (i_cmd_a == i_cmd_b);
    // A clear request only counts while latched and while both channels agree.
    assign w_clr   = i_fault_clr & r_fault & w_equal;

    // Next disagreement count: saturating run length, zeroed on agreement or clear.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_clr) begin
            w_cnt_nxt = 4'd0;
        end else if (!w_equal) begin
            if (r_cnt >= LIM) begin
                w_cnt_nxt = LIM;
            end else begin
                w_cnt_nxt = r_cnt + 4'd1;
            end
        end else begin
            w_cnt_nxt = 4'd0;
        end
    end

    // Counter and fault latch; the fault sets one cycle after the count hits the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_fault <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_fault <= w_clr ? 1'b0 : (r_fault | (r_cnt == LIM));
        end
    end

    assign o_fault   = r_fault;
    assign o_clr_evt = w_clr;

endmodule

// File: rtl/ctrl_pattern_gen.sv
// Relay driver with redundant-channel cross-check and a two-phase heartbeat
// (short/long) on the switch lines. A latched channel disagreement drops
// both relay lines to 0 and halts the heartbeat until cleared.
module ctrl_pattern_gen
    import ctrl_pattern_gen_pkg::*;
#(
    parameter int SHORT_LEN    = DEF_SHORT_LEN,
    parameter int LONG_LEN     = DEF_LONG_LEN,
    parameter int MISMATCH_LIM = DEF_MISMATCH_LIM
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic relayCmdA,
    input  logic relayCmdB,
    input  logic faultClr,
    output logic relayCtrl1,
    output logic relayCtrl2,
    output logic switchCtrl1,
    output logic switchCtrl2,
    output logic fault
);

    localparam logic [4:0] SHORT_LAST = phase_last(SHORT_LEN);
    localparam logic [4:0] LONG_LAST  = phase_last(LONG_LEN);

    logic [1:0] r_state;
    logic [4:0] r_phase;
    logic       r_relay1;
    logic       r_relay2;
    logic       r_sw1;
    logic       r_sw2;

    logic [1:0] w_state_nxt;
    logic [4:0] w_phase_nxt;
    logic       w_relay1_nxt;
    logic       w_relay2_nxt;
    logic       w_fault;
    logic       w_clr;

    mismatch_filter #(
        .MISMATCH_LIM (MISMATCH_LIM)
    ) u_filter (
        .clk         (clk),
        .rst         (rst),
        .i_cmd_a     (relayCmdA),
        .i_cmd_b     (relayCmdB),
        .i_fault_clr (faultClr),
        .o_fault     (w_fault),
        .o_clr_evt   (w_clr)
    );

    // Heartbeat next state: a latched fault overrides the enable, otherwise short/long alternate.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        if (w_fault) begin
            w_phase_nxt = 5'd0;
            w_state_nxt = w_clr ? ST_IDLE : ST_HALT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_phase_nxt = 5'd0;
                    if (en) begin
                        w_state_nxt = ST_SHORT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_SHORT: begin
                    if (!en) begin
                        w_state_nxt = ST_IDLE;
                        w_phase_nxt = 5'd0;
                    end else if (r_phase == SHORT_LAST) begin
                        w_state_nxt = ST_LONG;
                        w_phase_nxt = 5'd0;
                    end else begin
                        w_phase_nxt = r_phase + 5'd1;
                    end
                end
                ST_LONG: begin
                    if (!en) begin
                        w_state_nxt = ST_IDLE;
                        w_phase_nxt = 5'd0;
                    end else if (r_phase == LONG_LAST) begin
                        w_state_nxt = ST_SHORT;
                        w_phase_nxt = 5'd0;
                    end else begin
                        w_phase_nxt = r_phase + 5'd1;
                    end
                end
                ST_HALT: begin
                    // Unreachable without a fault; recover to a known state.
                    w_state_nxt = ST_IDLE;
                    w_phase_nxt = 5'd0;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_phase_nxt = 5'd0;
                end
            endcase
        end
    end

    // Relay next value: both low when faulted, follow agreeing channels, hold on disagreement.
    always_comb begin
        w_relay1_nxt = r_relay1;
        w_relay2_nxt = r_relay2;
        if (w_fault) begin
            w_relay1_nxt = 1'b0;
            w_relay2_nxt = 1'b0;
        end else if (relayCmdA == relayCmdB) begin
            w_relay1_nxt = relayCmdA;
            w_relay2_nxt = ~relayCmdA;
        end else begin
            w_relay1_nxt = r_relay1;
            w_relay2_nxt = r_relay2;
        end
    end

    // State, phase and registered outputs; switch lines decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_phase  <= 5'd0;
            r_relay1 <= 1'b0;
            r_relay2 <= 1'b0;
            r_sw1    <= 1'b0;
            r_sw2    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_phase  <= w_phase_nxt;
            r_relay1 <= w_relay1_nxt;
            r_relay2 <= w_relay2_nxt;
            r_sw1    <= (w_state_nxt == ST_SHORT);
            r_sw2    <= (w_state_nxt == ST_LONG);
        end
    end

    assign relayCtrl1  = r_relay1;
    assign relayCtrl2  = r_relay2;
    assign switchCtrl1 = r_sw1;
    assign switchCtrl2 = r_sw2;
    assign fault       = w_fault;

endmodule

// File: tb/tb_ctrl_pattern_gen.sv
// Bench for ctrl_pattern_gen: two instances (default lengths and 1/31) share
// the inputs and are compared every cycle against a cycle-level reference
// model that describes the heartbeat as a position within the period.
module tb_ctrl_pattern_gen;

    localparam int S0  = 2;
    localparam int L0  = 16;
    localparam int S1  = 1;
    localparam int L1  = 31;
    localparam int LIM = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic relayCmdA = 1'b0;
    logic relayCmdB = 1'b0;
    logic faultClr = 1'b0;

    logic o_r1 [2];
    logic o_r2 [2];
    logic o_s1 [2];
    logic o_s2 [2];
    logic o_f  [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state per instance.
    int   m_run     [2];
    logic m_fault   [2];
    logic m_r1      [2];
    logic m_r2      [2];
    logic m_running [2];
    int   m_t       [2];

    always #5 clk = ~clk;

    ctrl_pattern_gen dut0 (
        .clk (clk), .rst (rst), .en (en),
        .relayCmdA (relayCmdA), .relayCmdB (relayCmdB), .faultClr (faultClr),
        .relayCtrl1 (o_r1[0]), .relayCtrl2 (o_r2[0]),
        .switchCtrl1 (o_s1[0]), .switchCtrl2 (o_s2[0]), .fault (o_f[0])
    );

    ctrl_pattern_gen #(.SHORT_LEN(S1), .LONG_LEN(L1), .MISMATCH_LIM(LIM)) dut1 (
        .clk (clk), .rst (rst), .en (en),
        .relayCmdA (relayCmdA), .relayCmdB (relayCmdB), .faultClr (faultClr),
        .relayCtrl1 (o_r1[1]), .relayCtrl2 (o_r2[1]),
        .switchCtrl1 (o_s1[1]), .switchCtrl2 (o_s2[1]), .fault (o_f[1])
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    // Advance the model by one rising edge using the currently driven inputs.
    task automatic model_step(input int k);
        int   s_len;
        int   per;
        logic eq;
        logic clr;
        logic f_old;
        s_len = (k == 0) ? S0 : S1;
        per   = (k == 0) ? (S0 + L0) : (S1 + L1);
        if (rst) begin
            m_run[k] = 0; m_fault[k] = 1'b0; m_r1[k] = 1'b0; m_r2[k] = 1'b0;
            m_running[k] = 1'b0; m_t[k] = 0;
        end else begin
            eq    = (relayCmdA == relayCmdB);
            f_old = m_fault[k];
            clr   = faultClr && f_old && eq;
            m_fault[k] = clr ? 1'b0 : (f_old || (m_run[k] == LIM));
            if (clr || eq) m_run[k] = 0;
            else m_run[k] = (m_run[k] + 1 > LIM) ? LIM : m_run[k] + 1;
            if (f_old) begin
                m_r1[k] = 1'b0; m_r2[k] = 1'b0;
            end else if (eq) begin
                m_r1[k] = relayCmdA; m_r2[k] = !relayCmdA;
            end
            if (f_old) begin
                m_running[k] = 1'b0; m_t[k] = 0;
            end else if (!m_running[k]) begin
                m_running[k] = en; m_t[k] = 0;
            end else if (!en) begin
                m_running[k] = 1'b0; m_t[k] = 0;
            end else begin
                m_t[k] = m_t[k] + 1;
            end
        end
        if (per < 1) m_t[k] = 0;
    endtask

    task automatic check_all();
        int   s_len;
        int   per;
        logic e_s1;
        logic e_s2;
        for (int k = 0; k < 2; k++) begin
            s_len = (k == 0) ? S0 : S1;
            per   = (k == 0) ? (S0 + L0) : (S1 + L1);
            e_s1  = m_running[k] && ((m_t[k] % per) < s_len);
            e_s2  = m_running[k] && ((m_t[k] % per) >= s_len);
            chk($sformatf("dut%0d.relayCtrl1", k), o_r1[k], m_r1[k]);
            chk($sformatf("dut%0d.relayCtrl2", k), o_r2[k], m_r2[k]);
            chk($sformatf("dut%0d.switchCtrl1", k), o_s1[k], e_s1);
            chk($sformatf("dut%0d.switchCtrl2", k), o_s2[k], e_s2);
            chk($sformatf("dut%0d.fault", k), o_f[k], m_fault[k]);
        end
    endtask

    task automatic step(input logic t_rst, input logic t_en, input logic t_a,
                        input logic t_b, input logic t_clr);
        rst = t_rst; en = t_en; relayCmdA = t_a; relayCmdB = t_b; faultClr = t_clr;
        @(posedge clk);
        model_step(0);
        model_step(1);
        cyc++;
        #1;
        check_all();
    endtask

    initial begin
        int n_sw1;
        int n_sw2;
        int r;
        logic ra;

        // Reset state.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

        // Three full heartbeat periods with agreeing channels high.
        n_sw1 = 0; n_sw2 = 0;
        for (int i = 0; i < 3 * (S0 + L0); i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            n_sw1 += int'(o_s1[0]);
            n_sw2 += int'(o_s2[0]);
        end
        chk("sw1_high_cycles_3_periods", 1'(n_sw1 == 3 * S0), 1'b1);
        chk("sw2_high_cycles_3_periods", 1'(n_sw2 == 3 * L0), 1'b1);

        // Short disagreement burst: hold, no fault.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // Disagreement long enough to latch the fault.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("fault_latched", o_f[0], 1'b1);
        chk("relay_disable_signature", 1'(o_r1[0] == o_r2[0]), 1'b1);

        // Clear while still disagreeing is ignored, then a valid clear.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("after_clear_relay2", o_r2[0], 1'b1);

        // Drop enable in the middle of LONG, then re-enable.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < S0 + 5; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        // Fault arriving while the heartbeat runs, then reset overriding it.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < LIM + 1; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("reset_clears_fault", o_f[0], 1'b0);

        // Randomized stretch.
        for (int i = 0; i < 3000; i++) begin
            r  = int'($urandom_range(0, 299));
            ra = 1'($urandom_range(0, 1));
            step(1'(r == 0),
                 1'($urandom_range(0, 24) != 0),
                 ra,
                 ($urandom_range(0, 3) == 0) ? !ra : ra,
                 1'($urandom_range(0, 5) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
